hf14a_reader_tx_sequencer: RTL and testbench

//  Reader-side ISO14443-A frame sequencer for the HF datapath. Takes bytes from the ARM-side byte interface and

---
 rtl/hf14a_pkg.sv | 41 ++++
 rtl/hf14a_miller_symgen.sv | 51 +++++
 rtl/hf14a_reader_tx_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_hf14a_reader_tx_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hf14a_pkg.sv
// Shared types and helpers for the ISO14443-A reader transmit sequencer.
package hf14a_pkg;

    typedef enum logic [1:0] {
        SYM_X,
        SYM_Y,
        SYM_Z
    } sym_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_DATA,
        ST_PARITY,
        ST_EOF0,
        ST_EOF1,
        ST_LISTEN
    } state_t;

    // Pause start phases for the nominal 128-cycle symbol; scaled by the symbol generator.
    localparam int unsigned PHASE_X = 64;
    localparam int unsigned PHASE_Z = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [3:0] nbits;
        logic       par_en;
    } txbyte_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    function automatic sym_t miller_sym(input logic bit_v, input logic prev);
        if (bit_v)
            return SYM_X;
        return prev ? SYM_Y : SYM_Z;
    endfunction

endpackage

// File: rtl/hf14a_miller_symgen.sv
// Modified-Miller symbol timing: free-running phase counter per symbol and
// registered carrier-pause gate.
module hf14a_miller_symgen
    import hf14a_pkg::*;
#(
    parameter int unsigned BIT_PERIOD = 128,
    parameter int unsigned PAUSE_LEN  = 32
) (
    input  logic       ck_1356meg,
    input  logic       nrst,
    input  logic       sym_en,
    input  logic [1:0] sym,
    output logic       mod_pause,
    output logic       sym_end
);

    localparam int unsigned   PW      = $clog2(BIT_PERIOD);
    localparam int unsigned   PH_X    = PHASE_X * BIT_PERIOD / 128;
    localparam logic [PW-1:0] LAST_PH = PW'(BIT_PERIOD - 1);
    localparam logic [PW-1:0] X_LO    = PW'(PH_X);
    localparam logic [PW-1:0] X_HI    = PW'(PH_X + PAUSE_LEN - 1);
    localparam logic [PW-1:0] Z_HI    = PW'(PHASE_Z + PAUSE_LEN - 1);

    logic [PW-1:0] phase_q;
    logic          pause_d;

    always_comb begin
        pause_d = 1'b0;
        if (sym_en) begin
            case (sym)
                SYM_X:   pause_d = (phase_q >= X_LO) && (phase_q <= X_HI);
                SYM_Z:   pause_d = (phase_q <= Z_HI);
                default: pause_d = 1'b0;
            endcase
        end
    end

    assign sym_end = sym_en && (phase_q == LAST_PH);

    // Phase is held at 0 while no symbol is active, so a frame always starts at phase 0.
    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            phase_q   <= '0;
            mod_pause <= 1'b0;
        end else begin
            phase_q   <= sym_en ? phase_q + 1'b1 : '0;
            mod_pause <= pause_d;
        end
    end

endmodule

// File: rtl/hf14a_reader_tx_sequencer.sv
// Reader-side ISO14443-A frame sequencer: byte interface -> Modified-Miller pauses,
// then a listen window that timestamps the first tag modulation or times out.
module hf14a_reader_tx_sequencer
    import hf14a_pkg::*;
#(
    parameter int unsigned BIT_PERIOD  = 128,
    parameter int unsigned PAUSE_LEN   = 32,
    parameter int unsigned FDT_TIMEOUT = 4096,
    parameter int unsigned TS_WIDTH    = 16
) (
    input  logic                ck_1356meg,
    input  logic                nrst,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [7:0]          tx_data,
    input  logic                tx_last,
    input  logic [2:0]          tx_nbits,
    input  logic                tx_parity_en,
    input  logic                rx_curbit,
    output logic                mod_pause,
    output logic                listen_en,
    output logic                busy,
    output logic                ts_valid,
    output logic [TS_WIDTH-1:0] ts_value,
    output logic                ts_timeout,
    output logic                tx_underrun
);

    localparam int unsigned   LW          = $clog2(FDT_TIMEOUT);
    localparam logic [LW-1:0] LISTEN_LAST = LW'(FDT_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [7:0]    shift_q;
    logic [3:0]    bits_left_q;
    logic          par_q, par_bit_q, last_q, prev_q;
    txbyte_t       hold_q;
    logic          hold_full_q, last_seen_q;
    logic [LW-1:0] listen_cnt_q;

    sym_t          sym;
    logic          sym_en, sym_end;
    logic          accept, byte_done, load_hold, load_in, load_en;
    logic          underrun, det, tmo;
    logic [3:0]    in_nbits;
    txbyte_t       in_byte, load_byte;

    hf14a_miller_symgen #(
        .BIT_PERIOD(BIT_PERIOD),
        .PAUSE_LEN (PAUSE_LEN)
    ) u_symgen (
        .ck_1356meg(ck_1356meg),
        .nrst      (nrst),
        .sym_en    (sym_en),
        .sym       (sym),
        .mod_pause (mod_pause),
        .sym_end   (sym_end)
    );

    assign in_nbits = (tx_last && tx_nbits != 3'd0) ? {1'b0, tx_nbits} : 4'd8;

    always_comb begin
        in_byte.data   = tx_data;
        in_byte.last   = tx_last;
        in_byte.nbits  = in_nbits;
        in_byte.par_en = tx_parity_en && (in_nbits == 4'd8);
    end

    assign tx_ready = !hold_full_q &&
                      ((state_q == ST_IDLE) ||
                       ((state_q == ST_SOF || state_q == ST_DATA || state_q == ST_PARITY) && !last_seen_q));
    assign accept    = tx_valid && tx_ready;
    assign listen_en = (state_q == ST_LISTEN);
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        sym_en    = 1'b1;
        sym       = SYM_Y;
        byte_done = 1'b0;
        load_hold = 1'b0;
        load_in   = 1'b0;
        underrun  = 1'b0;
        det       = 1'b0;
        tmo       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                sym_en = 1'b0;
                if (accept)
                    state_d = ST_SOF;
            end
            ST_SOF: begin
                sym = SYM_Z;
                if (sym_end)
                    state_d = ST_DATA;
            end
            ST_DATA: begin
                sym = miller_sym(shift_q[0], prev_q);
                if (sym_end && bits_left_q == 4'd1) begin
                    if (par_q)
                        state_d = ST_PARITY;
                    else
                        byte_done = 1'b1;
                end
            end
            ST_PARITY: begin
                sym = miller_sym(par_bit_q, prev_q);
                if (sym_end)
                    byte_done = 1'b1;
            end
            ST_EOF0: begin
                sym = miller_sym(1'b0, prev_q);
                if (sym_end)
                    state_d = ST_EOF1;
            end
            ST_EOF1: begin
                sym = SYM_Y;
                if (sym_end)
                    state_d = ST_LISTEN;
            end
            ST_LISTEN: begin
                sym_en = 1'b0;
                if (rx_curbit) begin
                    det     = 1'b1;
                    state_d = ST_IDLE;
                end else if (listen_cnt_q == LISTEN_LAST) begin
                    tmo     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                sym_en  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // A byte offered in the very boundary cycle is taken straight into the shifter.
        if (byte_done) begin
            if (last_q) begin
                state_d = ST_EOF0;
            end else if (hold_full_q) begin
                load_hold = 1'b1;
                state_d   = ST_DATA;
            end else if (accept) begin
                load_in = 1'b1;
                state_d = ST_DATA;
            end else begin
                underrun = 1'b1;
                state_d  = ST_EOF0;
            end
        end
    end

    assign load_en   = (accept && state_q == ST_IDLE) || load_hold || load_in;
    assign load_byte = load_hold ? hold_q : in_byte;

    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            shift_q      <= '0;
            bits_left_q  <= '0;
            par_q        <= 1'b0;
            par_bit_q    <= 1'b0;
            last_q       <= 1'b0;
            prev_q       <= 1'b0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            last_seen_q  <= 1'b0;
            listen_cnt_q <= '0;
            ts_valid     <= 1'b0;
            ts_value     <= '0;
            ts_timeout   <= 1'b0;
            tx_underrun  <= 1'b0;
        end else begin
            tx_underrun  <= underrun;
            ts_valid     <= det;
            ts_timeout   <= tmo;
            listen_cnt_q <= (state_q == ST_LISTEN) ? listen_cnt_q + 1'b1 : '0;
            if (det)
                ts_value <= TS_WIDTH'(listen_cnt_q);

            if (accept) begin
                last_seen_q <= (state_q == ST_IDLE) ? tx_last : (last_seen_q | tx_last);
                if (state_q != ST_IDLE && !load_in) begin
                    hold_q      <= in_byte;
                    hold_full_q <= 1'b1;
                end
            end
            if (load_hold)
                hold_full_q <= 1'b0;

            if (sym_end) begin
                unique case (state_q)
                    ST_SOF:    prev_q <= 1'b0;
                    ST_PARITY: prev_q <= par_bit_q;
                    ST_DATA: begin
                        prev_q      <= shift_q[0];
                        shift_q     <= shift_q >> 1;
                        bits_left_q <= bits_left_q - 1'b1;
                    end
                    default: ;
                endcase
            end

            if (load_en) begin
                shift_q     <= load_byte.data;
                bits_left_q <= load_byte.nbits;
                par_q       <= load_byte.par_en;
                par_bit_q   <= odd_parity(load_byte.data);
                last_q      <= load_byte.last;
            end
        end
    end

endmodule

// File: tb/tb_hf14a_reader_tx_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench: frames are expanded into expected Miller symbols and listen/timestamp
// events; a monitor decodes the carrier-pause waveform and pops the expectations.
module tb_hf14a_reader_tx_sequencer;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_last = 1'b0;
    logic [2:0]  tx_nbits = '0;
    logic        tx_parity_en = 1'b0;
    logic        rx_curbit = 1'b0;
    logic        tx_ready, mod_pause, listen_en, busy, ts_valid, ts_timeout, tx_underrun;
    logic [15:0] ts_value;

    hf14a_reader_tx_sequencer #(
        .BIT_PERIOD (128),
        .PAUSE_LEN  (32),
        .FDT_TIMEOUT(4096),
        .TS_WIDTH   (16)
    ) dut (
        .ck_1356meg  (clk),
        .nrst        (nrst),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_last     (tx_last),
        .tx_nbits    (tx_nbits),
        .tx_parity_en(tx_parity_en),
        .rx_curbit   (rx_curbit),
        .mod_pause   (mod_pause),
        .listen_en   (listen_en),
        .busy        (busy),
        .ts_valid    (ts_valid),
        .ts_value    (ts_value),
        .ts_timeout  (ts_timeout),
        .tx_underrun (tx_underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_to;
        int val;
        int k;
    } ts_exp_t;

    int      total = 0;
    int      bad = 0;
    int      sym_q[$];
    int      listen_q[$];
    int      und_q[$];
    ts_exp_t ts_q[$];
    bit      mon_en = 1'b0;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Symbol codes: 0 = X, 1 = Y, 2 = Z, 3 = unrecognised waveform.
    function automatic int decode(input bit [127:0] p);
        bit [127:0] px = '0;
        bit [127:0] pz = '0;
        for (int i = 64; i < 96; i++) px[i] = 1'b1;
        for (int i = 0; i < 32; i++) pz[i] = 1'b1;
        if (p == px) return 0;
        if (p == '0) return 1;
        if (p == pz) return 2;
        return 3;
    endfunction

    // k counts negedges from the first one after the byte-accept edge; the pause
    // flop shows the symbol at phase p on negedge k = 128*sym + p + 1.
    initial begin : monitor
        bit         active;
        bit         lseen;
        int         k;
        bit [127:0] pat;
        ts_exp_t    e;
        active = 1'b0;
        lseen  = 1'b0;
        k      = 0;
        pat    = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                active = 1'b0;
            end else begin
                if (!active && busy) begin
                    active = 1'b1;
                    lseen  = 1'b0;
                    k      = 0;
                    pat    = '0;
                end else if (active) begin
                    k++;
                    if (!lseen) begin
                        pat[(k - 1) % 128] = mod_pause;
                        if ((k - 1) % 128 == 127) begin
                            if (sym_q.size() == 0)
                                chk("sym_extra", decode(pat), 9);
                            else
                                chk("symbol", decode(pat), sym_q.pop_front());
                            pat = '0;
                        end
                        if (listen_en) begin
                            lseen = 1'b1;
                            if (listen_q.size() == 0)
                                chk("listen_unexpected", int'(listen_en), 0);
                            else
                                chk("listen_start_cycle", k, listen_q.pop_front());
                        end
                    end
                end
                if (tx_underrun) begin
                    if (und_q.size() == 0)
                        chk("underrun_unexpected", int'(tx_underrun), 0);
                    else
                        chk("underrun_cycle", k, und_q.pop_front());
                end
                if (ts_valid || ts_timeout) begin
                    if (ts_q.size() == 0) begin
                        chk("ts_unexpected", int'(ts_valid | ts_timeout), 0);
                    end else begin
                        e = ts_q.pop_front();
                        chk("ts_timeout_flag", int'(ts_timeout), int'(e.is_to));
                        chk("ts_valid_flag", int'(ts_valid), int'(!e.is_to));
                        chk("ts_cycle", k, e.k);
                        if (!e.is_to)
                            chk("ts_value", int'(ts_value), e.val);
                        chk("busy_after_ts", int'(busy), 0);
                    end
                    active = 1'b0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic last, input logic [2:0] nb,
                             input logic par, output int waited);
        @(negedge clk);
        tx_valid     = 1'b1;
        tx_data      = d;
        tx_last      = last;
        tx_nbits     = nb;
        tx_parity_en = par;
        waited       = 0;
        while (!tx_ready && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        chk("byte_accepted", int'(tx_ready), 1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        tx_last  = 1'($urandom);
        tx_nbits = 3'($urandom);
    endtask

    // close=0 leaves the final byte without tx_last, so the frame must end on underrun.
    task automatic run_frame(input int nb, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [2:0] nbl, input logic par,
                             input bit close, input int resp);
        logic [7:0] ds [3];
        int         bits[$];
        int         syms[$];
        int         prev, n, nsym, w;
        ts_exp_t    e;
        ds[0] = d0;
        ds[1] = d1;
        ds[2] = d2;
        for (int i = 0; i < nb; i++) begin
            bit         lst;
            logic [7:0] d;
            lst = close && (i == nb - 1);
            d   = ds[i];
            n   = (lst && nbl != 3'd0) ? int'(nbl) : 8;
            for (int j = 0; j < n; j++) bits.push_back(int'(d[j]));
            if (par && n == 8) bits.push_back(($countones(d) % 2 == 0) ? 1 : 0);
        end
        syms.push_back(2);
        prev = 0;
        foreach (bits[i]) begin
            syms.push_back(bits[i] == 1 ? 0 : (prev == 1 ? 1 : 2));
            prev = bits[i];
        end
        syms.push_back(prev == 1 ? 1 : 2);
        syms.push_back(1);
        nsym = syms.size();
        foreach (syms[i]) sym_q.push_back(syms[i]);
        listen_q.push_back(128 * nsym);
        if (!close) und_q.push_back(128 * (bits.size() + 1));
        if (resp < 4096) begin
            e.is_to = 1'b0;
            e.val   = resp;
            e.k     = 128 * nsym + resp + 1;
        end else begin
            e.is_to = 1'b1;
            e.val   = 0;
            e.k     = 128 * nsym + 4096;
        end
        ts_q.push_back(e);

        for (int i = 0; i < nb; i++) begin
            bit lst;
            lst = close && (i == nb - 1);
            send_byte(ds[i], lst, lst ? nbl : 3'($urandom), par, w);
            if (i == 1) chk("ready_during_first_byte", w, 0);
        end

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!listen_en && n < 8000);
        chk("listen_reached", int'(listen_en), 1);
        if (resp < 4096 && listen_en) begin
            repeat (resp) @(posedge clk);
            if (resp > 0) #1;
            rx_curbit = 1'b1;
        end
        n = 0;
        while (busy && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_back_to_idle", int'(busy), 0);
        rx_curbit = 1'b0;
        repeat (3) @(negedge clk);
        chk("sym_q_drained", sym_q.size(), 0);
        chk("ts_q_drained", ts_q.size(), 0);
        chk("und_q_drained", und_q.size(), 0);
        chk("listen_q_drained", listen_q.size(), 0);
    endtask

    initial begin : watchdog
        #900_000;
        bad++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", int'(tx_ready), 1);
        chk("rst_mod_pause", int'(mod_pause), 0);
        chk("rst_listen_en", int'(listen_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ts_valid", int'(ts_valid), 0);
        chk("rst_ts_value", int'(ts_value), 0);
        chk("rst_ts_timeout", int'(ts_timeout), 0);
        chk("rst_tx_underrun", int'(tx_underrun), 0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        run_frame(1, 8'h26, 8'h00, 8'h00, 3'd7, 1'b0, 1'b1, 1000);
        run_frame(1, 8'h26, 8'h00, 8'h00, 3'd7, 1'b0, 1'b1, 5000);
        run_frame(1, 8'h26, 8'h00, 8'h00, 3'd7, 1'b0, 1'b1, 4095);
        run_frame(1, 8'h26, 8'h00, 8'h00, 3'd7, 1'b0, 1'b1, 0);
        run_frame(2, 8'h93, 8'h20, 8'h00, 3'd0, 1'b1, 1'b1, 300);
        run_frame(1, 8'h93, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 500);

        // Asynchronous reset during the X pause of symbol 3.
        mon_en = 1'b0;
        @(negedge clk);
        send_byte(8'h26, 1'b1, 3'd7, 1'b0, w);
        repeat (454) @(posedge clk);
        #1;
        chk("pause_before_reset", int'(mod_pause), 1);
        nrst = 1'b0;
        #1;
        chk("reset_mod_pause", int'(mod_pause), 0);
        chk("reset_listen_en", int'(listen_en), 0);
        chk("reset_busy", int'(busy), 0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("release_tx_ready", int'(tx_ready), 1);
        chk("release_busy", int'(busy), 0);
        mon_en = 1'b1;
        @(negedge clk);

        for (int f = 0; f < 4; f++) begin
            int nb;
            nb = int'($urandom_range(1, 3));
            run_frame(nb, 8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                      1'($urandom), ($urandom_range(0, 3) != 0), int'($urandom_range(0, 1500)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
